rv_decode_stage: RTL
====================

// Module: rv_decode_stage
// PURPOSE
// - Registered RV32I decode stage replacing the combinational control unit; sits between fetch and execute.
// - Accepts one instruction per cycle over valid/ready, emits a decoded control bundle plus rs1/rs2/rd and PC.
// - Adds illegal-instruction and SYSTEM (ecall/ebreak) detection, optional M-extension decode, flush and a 2-entry skid buffer.
// PARAMETERS
// - XLEN      32  PC width carried through the stage
// - ENABLE_M   0  1: decode MUL/DIV (funct7=0000001) as legal, md=1; 0: those encodings are illegal
// - SKID       1  1: 2-entry skid buffer, in_ready is registered; 0: single register, in_ready = !full | out_ready
// PORTS
// - clk          in   1     rising-edge clock
// - rst_n        in   1     async active-low reset
// - flush        in   1     drop all held and incoming instructions this cycle
// - in_valid     in   1     fetch presents instruction
// - in_ready     out  1     stage can accept
// - in_instr     in   32    raw instruction
// - in_pc        in   XLEN  instruction PC
// - out_valid    out  1     decoded entry available
// - out_ready    in   1     execute accepts
// - out_pc       out  XLEN  PC of out entry
// - out_rs1/out_rs2/out_rd  out 5 each  register indices (rd forced 0 when we=0)
// - out_ctrl     out  CTRL_W  rv_decode_pkg::ctrl_t bundle
// - out_illegal  out  1     undefined encoding; ctrl forced to NOP (we=0, store=0, br_op=0)
// - out_sys      out  2     01 ecall, 10 ebreak, 00 otherwise
// BEHAVIOUR
// - Reset (async, rst_n=0): buffer empty, out_valid=0, in_ready=0 during reset then 1 on first clock after release; all data outputs 0.
// - Transfer on in_valid&in_ready (input) and out_valid&out_ready (output); no combinational path in_valid->out_valid.
// - Latency 1 cycle: instruction accepted at edge N is on out_* after edge N; throughput 1/cycle when out_ready held 1.
// - Buffer states EMPTY/ONE/TWO (SKID=1): EMPTY-push->ONE; ONE-push&!pop->TWO; ONE-pop&!push->EMPTY; TWO-pop->ONE; push&pop in ONE stays ONE.
// - in_ready = (state!=TWO), registered; out_valid = (state!=EMPTY); out_* always show oldest entry; order preserved.
// - out_* stable while out_valid & !out_ready (no change until pop).
// - flush: next state EMPTY, out_valid=0 next cycle, concurrent input push discarded; flush dominates push and pop.
// - Decode (fields: opcode[6:0], funct3[14:12], funct7[31:25]):
//   OP/OP-IMM: alu_op=funct3, alu_sub=1 for SUB, SRA, SRAI, SLTU, SLTIU (alu_op 010 for sltu/sltiu); alu_src_imm=1 for OP-IMM; rf_sel=01, we=1.
//   SLLI/SRLI/SRAI with funct7 not 0000000/0100000 (SLLI: not 0000000) -> illegal. OP funct7 other than 0000000/0100000(SUB,SRL only)/0000001(ENABLE_M) -> illegal.
//   LOAD: dm_type lb000 lh001 lw010 lbu011 lhu100; funct3 011/110/111 illegal; rf_sel=00, we=1, imm_type=000.
//   STORE: store=1, dm_type=funct3 (000/001/010 only, else illegal), imm_type=001, we=0.
//   BRANCH: br_op={2'b01,funct3}, funct3 010/011 illegal; op1_pc=1, alu_src_imm=1, imm_type=010.
//   LUI: alu_op=100, imm_type=011; AUIPC: alu_op=000, op1_pc=1, imm_type=011; both we=1, rf_sel=01.
//   JALR (funct3=000 else illegal): imm_type=000, op1_pc=0; JAL: imm_type=100, op1_pc=1; both br_op=11111, rf_sel=11, we=1.
//   SYSTEM: instr==0x00000073 -> sys=01; 0x00100073 -> sys=10; other SYSTEM illegal; ctrl=NOP.
//   FENCE (0001111): legal NOP. Any other opcode or instr[1:0]!=11 -> illegal.
// - Every ctrl field has a defined value for every opcode (no latch inference; default = NOP).
// - rd==0 with we=1: we forced 0.
// STRUCTURE
// - rv_decode_pkg: ctrl_t packed struct, CTRL_W, opcode localparams, ALU_OP_*, DM_*, IMM_*, BR_*, RF_SEL_*, NOP_CTRL constant.
// - Sub-module rv_decode_comb: pure combinational instr -> {ctrl, illegal, sys}; top holds skid buffer and handshake.
// TESTING
// - Reset mid-stream: rst_n=0 with TWO entries held -> out_valid=0 immediately, buffer EMPTY after release.
// - Stream add/sub/sra/srai/sltu with out_ready=1 -> one result/cycle, 1-cycle latency; sra/srai give alu_op=101, alu_sub=1.
// - Backpressure: push 3 instrs, out_ready=0 -> in_ready=0 after 2; release -> PCs 0x0,0x4,0x8 in order, no loss/duplication.
// - Flush while TWO held and in_valid=1 -> next cycle out_valid=0, the three instructions never appear.
// - 0x00000073 -> sys=01; 0x00100073 -> sys=10; 0x00003003 (ld) -> illegal=1, we=0; 0x02000033 -> illegal iff ENABLE_M=0.
// - addi x0,x0,1 (0x00100013) -> we=0, out_rd=0; jal x1,8 -> br_op=11111, rf_sel=11, imm_type=100, we=1.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared types and encodings for the RV32I decode stage.
// ctrl_t is the control bundle handed to execute; dec_t is one buffered entry minus its PC.
package rv_decode_pkg;

  localparam int unsigned CTRL_W = 22;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SLT = 3'b010;
  localparam logic [2:0] ALU_OP_LUI = 3'b100;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b011;
  localparam logic [2:0] DM_HU = 3'b100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b11111;

  localparam logic [1:0] RF_SEL_MEM = 2'b00;
  localparam logic [1:0] RF_SEL_ALU = 2'b01;
  localparam logic [1:0] RF_SEL_PC4 = 2'b11;

  localparam logic [1:0] SYS_NONE   = 2'b00;
  localparam logic [1:0] SYS_ECALL  = 2'b01;
  localparam logic [1:0] SYS_EBREAK = 2'b10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_sub;
    logic       alu_src_imm;
    logic       op1_pc;
    logic [1:0] rf_sel;
    logic       we;
    logic       store;
    logic [2:0] dm_type;
    logic [2:0] imm_type;
    logic [4:0] br_op;
    logic       md;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    ctrl_t      ctrl;
    logic       illegal;
    logic [1:0] sys;
  } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I(+M) decoder: raw instruction -> control bundle, illegal flag, ecall/ebreak.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int unsigned ENABLE_M = 0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl_c,
  output logic        illegal_c,
  output logic [1:0]  sys_c
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  ctrl_t      dec;
  logic       bad;
  logic [1:0] sys;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec = NOP_CTRL;
    bad = 1'b0;
    sys = SYS_NONE;
    case (opcode)
      OPC_OP: begin
        dec.alu_op = funct3;
        dec.rf_sel = RF_SEL_ALU;
        dec.we     = 1'b1;
        if (funct7 == 7'b0000000) begin
          if (funct3 == 3'b011) begin
            dec.alu_op  = ALU_OP_SLT;
            dec.alu_sub = 1'b1;
          end
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_sub = 1'b1;
        end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
          dec.md = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.alu_op      = funct3;
        dec.alu_src_imm = 1'b1;
        dec.rf_sel      = RF_SEL_ALU;
        dec.we          = 1'b1;
        case (funct3)
          3'b001: bad = (funct7 != 7'b0000000);
          3'b101: begin
            if (funct7 == 7'b0100000) dec.alu_sub = 1'b1;
            else if (funct7 != 7'b0000000) bad = 1'b1;
          end
          3'b011: begin
            dec.alu_op  = ALU_OP_SLT;
            dec.alu_sub = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_LOAD: begin
        dec.alu_src_imm = 1'b1;
        dec.rf_sel      = RF_SEL_MEM;
        dec.we          = 1'b1;
        dec.imm_type    = IMM_I;
        case (funct3)
          3'b000:  dec.dm_type = DM_B;
          3'b001:  dec.dm_type = DM_H;
          3'b010:  dec.dm_type = DM_W;
          3'b100:  dec.dm_type = DM_BU;
          3'b101:  dec.dm_type = DM_HU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.alu_src_imm = 1'b1;
        dec.store       = 1'b1;
        dec.dm_type     = funct3;
        dec.imm_type    = IMM_S;
        bad             = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.br_op       = {2'b01, funct3};
        dec.op1_pc      = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm_type    = IMM_B;
        bad             = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      OPC_LUI: begin
        dec.alu_op      = ALU_OP_LUI;
        dec.alu_src_imm = 1'b1;
        dec.imm_type    = IMM_U;
        dec.rf_sel      = RF_SEL_ALU;
        dec.we          = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_op      = ALU_OP_ADD;
        dec.op1_pc      = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm_type    = IMM_U;
        dec.rf_sel      = RF_SEL_ALU;
        dec.we          = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_src_imm = 1'b1;
        dec.imm_type    = IMM_I;
        dec.br_op       = BR_JUMP;
        dec.rf_sel      = RF_SEL_PC4;
        dec.we          = 1'b1;
        bad             = (funct3 != 3'b000);
      end
      OPC_JAL: begin
        dec.alu_src_imm = 1'b1;
        dec.op1_pc      = 1'b1;
        dec.imm_type    = IMM_J;
        dec.br_op       = BR_JUMP;
        dec.rf_sel      = RF_SEL_PC4;
        dec.we          = 1'b1;
      end
      OPC_SYSTEM: begin
        if (instr == 32'h0000_0073) sys = SYS_ECALL;
        else if (instr == 32'h0010_0073) sys = SYS_EBREAK;
        else bad = 1'b1;
      end
      OPC_FENCE: ;
      default: bad = 1'b1;
    endcase
    // Illegal encodings become a bubble; writes to x0 are suppressed.
    if (bad) begin
      dec = NOP_CTRL;
      sys = SYS_NONE;
    end
    if (instr[11:7] == 5'd0) dec.we = 1'b0;
  end

  assign ctrl_c    = dec;
  assign illegal_c = bad;
  assign sys_c     = sys;

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: decodes on input and holds results in a 2-entry skid buffer
// (or a single pipeline register when SKID=0), presenting the oldest entry to execute.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENABLE_M = 0,
  parameter int unsigned SKID     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output ctrl_t           out_ctrl,
  output logic            out_illegal,
  output logic [1:0]      out_sys
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state, state_nxt;
  logic            rdy_q, rdy_nxt;
  logic            push, pop;
  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  logic [1:0]      dec_sys;
  dec_t            in_dec, slot0, slot1;
  logic [XLEN-1:0] pc0, pc1;

  rv_decode_comb #(.ENABLE_M(ENABLE_M)) u_comb (
    .instr     (in_instr),
    .ctrl_c    (dec_ctrl),
    .illegal_c (dec_illegal),
    .sys_c     (dec_sys)
  );

  always_comb begin
    in_dec         = '0;
    in_dec.rs1     = in_instr[19:15];
    in_dec.rs2     = in_instr[24:20];
    in_dec.rd      = dec_ctrl.we ? in_instr[11:7] : 5'd0;
    in_dec.ctrl    = dec_ctrl;
    in_dec.illegal = dec_illegal;
    in_dec.sys     = dec_sys;
  end

  assign in_ready  = (SKID != 0) ? rdy_q : (rdy_q & ((state == EMPTY) | out_ready));
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= rdy_nxt;
    end
  end

  // Occupancy FSM; flush wins over any concurrent push or pop.
  always_comb begin
    state_nxt = state;
    rdy_nxt   = 1'b1;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop) state_nxt = TWO;
          else if (pop && !push) state_nxt = EMPTY;
        end
        TWO:     if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
    rdy_nxt = (SKID == 0) || (state_nxt != TWO);
  end

  // slot0 is always the oldest entry; slot1 only fills while slot0 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      pc0   <= '0;
      pc1   <= '0;
    end else if (!flush) begin
      if (pop && state == TWO) begin
        slot0 <= slot1;
        pc0   <= pc1;
      end else if (push && (state == EMPTY || pop)) begin
        slot0 <= in_dec;
        pc0   <= in_pc;
      end else if (push) begin
        slot1 <= in_dec;
        pc1   <= in_pc;
      end
    end
  end

  assign out_pc      = pc0;
  assign out_rs1     = slot0.rs1;
  assign out_rs2     = slot0.rs2;
  assign out_rd      = slot0.rd;
  assign out_ctrl    = slot0.ctrl;
  assign out_illegal = slot0.illegal;
  assign out_sys     = slot0.sys;

endmodule
